// File: rtl/line_clearer.sv
// line_clearer: post-lock line-clear engine; scans bottom-up, collapses full rows, counts lines.
// Package game_state_pkg holds the playfield type shared with the executioner.
// Ports: game_clk, reset (sync, active-high), start, GAME_fixed_state in;
//        GAME_cleared_state, clearing_line, done, lines_this_pass, lines_total out;
//        score out only when LINE_CLEARER_SCORE_EN is defined.
package game_state_pkg;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  typedef struct packed {
    logic [ROWS-1:0][COLS-1:0] screen;
  } game_state_t;
  localparam game_state_t blank_game_state = '0;
endpackage

module line_clearer #(
  parameter int ROWS = game_state_pkg::ROWS,
  parameter int COLS = game_state_pkg::COLS,
  parameter int TOTAL_W = 16,
  localparam int CW = $clog2(ROWS + 1),
  localparam int RW = $clog2(ROWS)
) (
  input  logic                        game_clk,
  input  logic                        reset,
  input  logic                        start,
  input  game_state_pkg::game_state_t GAME_fixed_state,
  output game_state_pkg::game_state_t GAME_cleared_state,
  output logic                        clearing_line,
  output logic                        done,
  output logic [CW-1:0]               lines_this_pass,
  output logic [TOTAL_W-1:0]          lines_total
`ifdef LINE_CLEARER_SCORE_EN
  ,
  output logic [31:0]                 score
`endif
);
  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;
  state_t state_q;
  logic [ROWS-1:0][COLS-1:0] buf_q, shift_d;
  logic [RW-1:0] row_q;
  logic row_full;
  assign row_full = &buf_q[row_q];
  // Rows at or above row_q drop by one, row 0 empties, rows below row_q stay put.
  for (genvar r = 0; r < ROWS; r++) begin : g_shift
    if (r == 0) begin : g_top
      assign shift_d[r] = (RW'(r) > row_q) ? buf_q[r] : '0;
    end else begin : g_rest
      assign shift_d[r] = (RW'(r) > row_q) ? buf_q[r] : buf_q[r-1];
    end
  end
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q            <= IDLE;
      buf_q              <= '0;
      row_q              <= '0;
      clearing_line      <= 1'b0;
      done               <= 1'b0;
      lines_this_pass    <= '0;
      lines_total        <= '0;
      GAME_cleared_state <= game_state_pkg::blank_game_state;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          buf_q           <= GAME_fixed_state.screen;
          row_q           <= RW'(ROWS - 1);
          lines_this_pass <= '0;
          clearing_line   <= 1'b1;
          state_q         <= SCAN;
        end
        SCAN: if (row_full) begin
          state_q <= SHIFT;
        end else if (row_q == '0) begin
          GAME_cleared_state.screen <= buf_q;
          done                      <= 1'b1;
          state_q                   <= DONE;
        end else begin
          row_q <= row_q - 1'b1;
        end
        SHIFT: begin
          buf_q           <= shift_d;
          lines_this_pass <= lines_this_pass + 1'b1;
          lines_total     <= lines_total + 1'b1;
          state_q         <= SCAN;
        end
        DONE: begin
          clearing_line <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef LINE_CLEARER_SCORE_EN
  logic [31:0] pts;
  logic [32:0] sum;
  always_comb begin
    pts = (lines_this_pass == CW'(0)) ? 32'd0 :
          (lines_this_pass == CW'(1)) ? 32'd40 :
          (lines_this_pass == CW'(2)) ? 32'd100 :
          (lines_this_pass == CW'(3)) ? 32'd300 : 32'd1200;
    sum = {1'b0, score} + {1'b0, pts};
  end
  // Awarded on the edge that enters DONE so score is current alongside done.
  always_ff @(posedge game_clk) begin
    if (reset) score <= '0;
    else if (state_q == SCAN && !row_full && row_q == '0) score <= sum[32] ? '1 : sum[31:0];
  end
`endif
endmodule

// File: tb/tb_line_clearer.sv
// tb_line_clearer: randomized and directed self-checking bench for line_clearer.
module tb_line_clearer;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  typedef logic [ROWS-1:0][COLS-1:0] scr_t;
  logic game_clk = 1'b0;
  logic reset, start;
  game_state_pkg::game_state_t fixed_st, cleared_st;
  logic clearing_line, done;
  logic [4:0] lines_this_pass;
  logic [15:0] lines_total;
  logic [31:0] score;
  int errors = 0;
  int checks = 0;
  longint exp_total = 0;
  longint exp_score = 0;
  always #5 game_clk = ~game_clk;
  line_clearer dut (
    .game_clk(game_clk),
    .reset(reset),
    .start(start),
    .GAME_fixed_state(fixed_st),
    .GAME_cleared_state(cleared_st),
    .clearing_line(clearing_line),
    .done(done),
    .lines_this_pass(lines_this_pass),
    .lines_total(lines_total)
`ifdef LINE_CLEARER_SCORE_EN
    ,
    .score(score)
`endif
  );
`ifndef LINE_CLEARER_SCORE_EN
  assign score = '0;
`endif
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Reference: drop every full row, keep the rest in bottom-to-top order, pad empties on top.
  function automatic void model(input scr_t b, output scr_t c, output int k);
    logic [COLS-1:0] keep[$];
    k = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (b[r] == {COLS{1'b1}}) k++;
      else keep.push_back(b[r]);
    end
    c = '0;
    foreach (keep[i]) c[ROWS-1-i] = keep[i];
  endfunction
  task automatic run_pass(input string name, input scr_t b, input bit extra_start);
    scr_t c;
    int k, n, hi;
    longint pts;
    model(b, c, k);
    exp_total = (exp_total + k) % 65536;
    pts = (k == 0) ? 0 : (k == 1) ? 40 : (k == 2) ? 100 : (k == 3) ? 300 : 1200;
    exp_score = (exp_score + pts > 64'hFFFFFFFF) ? 64'hFFFFFFFF : exp_score + pts;
    fixed_st.screen = b;
    start = 1'b1;
    @(posedge game_clk);
    #1 start = 1'b0;
    n = 0;
    hi = 0;
    while (!done && n < 200) begin
      if (clearing_line) hi++;
      if (extra_start && n == 5) begin
        start = 1'b1;
        fixed_st.screen = '1;
      end
      @(posedge game_clk);
      #1;
      n++;
      if (extra_start && n == 6) start = 1'b0;
    end
    check({name, " latency"}, n, ROWS + 2 * k);
    check({name, " busy_cycles"}, hi, ROWS + 2 * k);
    check({name, " busy_at_done"}, clearing_line, 1'b1);
    check({name, " lines_this_pass"}, lines_this_pass, k);
    check({name, " screen"}, cleared_st.screen, c);
    check({name, " lines_total"}, lines_total, exp_total[15:0]);
`ifdef LINE_CLEARER_SCORE_EN
    check({name, " score"}, score, exp_score[31:0]);
`endif
    @(posedge game_clk);
    #1;
    check({name, " done_pulse"}, done, 1'b0);
    check({name, " idle"}, clearing_line, 1'b0);
    check({name, " screen_hold"}, cleared_st.screen, c);
  endtask
  initial begin
    scr_t b;
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    fixed_st = '0;
    repeat (2) @(posedge game_clk);
    #1;
    check("rst clearing_line", clearing_line, 1'b0);
    check("rst done", done, 1'b0);
    check("rst lines_this_pass", lines_this_pass, 0);
    check("rst lines_total", lines_total, 0);
    check("rst cleared", cleared_st, '0);
    check("rst score", score, 0);
    reset = 1'b0;
    b = '0;
    run_pass("empty", b, 1'b0);
    b = '0;
    b[19] = '1;
    b[18] = 10'b1000000001;
    run_pass("one_row", b, 1'b0);
    check("one_row row19", cleared_st.screen[19], 10'b1000000001);
    b = '0;
    for (int r = 16; r < 20; r++) b[r] = '1;
    b[15] = 10'b0000000001;
    run_pass("tetris", b, 1'b0);
    b = '0;
    b[19] = '1;
    b[17] = '1;
    b[0] = '1;
    b[18] = 10'b0000011111;
    run_pass("split", b, 1'b1);
    check("split row19", cleared_st.screen[19], 10'b0000011111);
    run_pass("split_again", b, 1'b0);
    for (int t = 0; t < 12; t++) begin
      for (int r = 0; r < ROWS; r++)
        b[r] = ($urandom % 3 == 0) ? '1 : (($urandom % 4 == 0) ? '0 : COLS'($urandom));
      run_pass($sformatf("rand%0d", t), b, ($urandom % 2) == 1);
    end
    b = '0;
    b[19] = '1;
    fixed_st.screen = b;
    start = 1'b1;
    @(posedge game_clk);
    #1 start = 1'b0;
    @(posedge game_clk);
    #1 reset = 1'b1;
    @(posedge game_clk);
    #1 reset = 1'b0;
    exp_total = 0;
    exp_score = 0;
    check("shift_rst clearing_line", clearing_line, 1'b0);
    check("shift_rst done", done, 1'b0);
    check("shift_rst lines_total", lines_total, 0);
    check("shift_rst lines_this_pass", lines_this_pass, 0);
    check("shift_rst cleared", cleared_st, '0);
    check("shift_rst score", score, 0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge game_clk);
      #1;
      if (done || clearing_line) pulses++;
    end
    check("shift_rst quiet", pulses, 0);
    run_pass("after_rst", b, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
